// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of fetch-time branch predictions.
// Checks each resolve against its prediction, updates branch_cache and redirects fetch on a miss.
// Ports:
//   iCLOCK/iRESET (async, active-high), iFLUSH (sync clear)
//   iPUSH_* / oPUSH_FULL      : decode enqueues a predicted branch
//   iRESOLVE_* / oRESOLVE_ERROR: execute resolves the oldest branch
//   oJUMP_*                   : branch_cache jump-update port
//   oMISS_*                   : fetch redirect on misprediction
//   oCOUNT, oSTAT_*           : occupancy and statistics
// Build option: BRANCH_RESOLVE_STAT_EN builds the resolve/miss counters.
module branch_resolve_queue #(
    parameter int DEPTH   = 4,
    parameter int DEPTH_N = 2
) (
    input  logic               iCLOCK,
    input  logic               iRESET,
    input  logic               iFLUSH,
    input  logic               iPUSH_STB,
    input  logic [31:0]        iPUSH_INST_ADDR,
    input  logic               iPUSH_PREDICT_HIT,
    input  logic               iPUSH_PREDICT_BRANCH,
    input  logic [31:0]        iPUSH_PREDICT_ADDR,
    output logic               oPUSH_FULL,
    input  logic               iRESOLVE_STB,
    input  logic               iRESOLVE_TAKEN,
    input  logic [31:0]        iRESOLVE_ADDR,
    output logic               oRESOLVE_ERROR,
    output logic               oJUMP_STB,
    output logic               oJUMP_VALID,
    output logic [31:0]        oJUMP_ADDR,
    output logic [31:0]        oJUMP_INST_ADDR,
    output logic               oMISS_STB,
    output logic [31:0]        oMISS_ADDR,
    output logic [DEPTH_N:0]   oCOUNT,
    output logic [31:0]        oSTAT_RESOLVE,
    output logic [31:0]        oSTAT_MISS
);

    logic [31:0]        r_ent_inst  [DEPTH];
    logic [31:0]        r_ent_paddr [DEPTH];
    logic               r_ent_hit   [DEPTH];
    logic               r_ent_br    [DEPTH];

    logic [DEPTH_N-1:0] r_wp;
    logic [DEPTH_N-1:0] r_rp;
    logic [DEPTH_N:0]   r_count;

    logic               r_jump_stb;
    logic               r_jump_valid;
    logic [31:0]        r_jump_addr;
    logic [31:0]        r_jump_inst;
    logic               r_miss_stb;
    logic [31:0]        r_miss_addr;
    logic               r_err;

    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_pred_taken;
    logic               w_miss;
    logic               w_push;
    logic [31:0]        w_head_inst;

    assign w_full       = (r_count == (DEPTH_N+1)'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_pop        = iRESOLVE_STB && !w_empty && !iFLUSH;
    assign w_head_inst  = r_ent_inst[r_rp];
    assign w_pred_taken = r_ent_hit[r_rp] & r_ent_br[r_rp];
    assign w_miss       = (w_pred_taken != iRESOLVE_TAKEN) |
                          (iRESOLVE_TAKEN & w_pred_taken &
                           (r_ent_paddr[r_rp] != iRESOLVE_ADDR));
    // A push in the cycle of a mispredicted resolve is on the wrong path.
    assign w_push       = iPUSH_STB && !iFLUSH && (!w_full || w_pop) &&
                          !(w_pop && w_miss);

    // Entry storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge iCLOCK) begin
        if (w_push) begin
            r_ent_inst[r_wp]  <= iPUSH_INST_ADDR;
            r_ent_paddr[r_wp] <= iPUSH_PREDICT_ADDR;
            r_ent_hit[r_wp]   <= iPUSH_PREDICT_HIT;
            r_ent_br[r_wp]    <= iPUSH_PREDICT_BRANCH;
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (iFLUSH || (w_pop && w_miss)) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // Strobes clear on flush because w_pop and the error term gate on it.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_jump_stb   <= 1'b0;
            r_jump_valid <= 1'b0;
            r_jump_addr  <= '0;
            r_jump_inst  <= '0;
            r_miss_stb   <= 1'b0;
            r_miss_addr  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_jump_stb <= w_pop;
            r_miss_stb <= w_pop && w_miss;
            r_err      <= iRESOLVE_STB && w_empty && !iFLUSH;
            if (w_pop) begin
                r_jump_valid <= iRESOLVE_TAKEN;
                r_jump_addr  <= iRESOLVE_ADDR;
                r_jump_inst  <= w_head_inst;
            end
            if (w_pop && w_miss) begin
                r_miss_addr <= iRESOLVE_TAKEN ? iRESOLVE_ADDR
                                              : w_head_inst + 32'h4;
            end
        end
    end

`ifdef BRANCH_RESOLVE_STAT_EN
    logic [31:0] r_stat_res;
    logic [31:0] r_stat_miss;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_stat_res  <= '0;
            r_stat_miss <= '0;
        end else begin
            if (w_pop)           r_stat_res  <= r_stat_res + 32'd1;
            if (w_pop && w_miss) r_stat_miss <= r_stat_miss + 32'd1;
        end
    end

    assign oSTAT_RESOLVE = r_stat_res;
    assign oSTAT_MISS    = r_stat_miss;
`else
    assign oSTAT_RESOLVE = 32'h0;
    assign oSTAT_MISS    = 32'h0;
`endif

    assign oPUSH_FULL      = w_full;
    assign oCOUNT          = r_count;
    assign oRESOLVE_ERROR  = r_err;
    assign oJUMP_STB       = r_jump_stb;
    assign oJUMP_VALID     = r_jump_valid;
    assign oJUMP_ADDR      = r_jump_addr;
    assign oJUMP_INST_ADDR = r_jump_inst;
    assign oMISS_STB       = r_miss_stb;
    assign oMISS_ADDR      = r_miss_addr;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Testbench for branch_resolve_queue.
// Directed steps with a reference queue model and an output scoreboard.
module tb_branch_resolve_queue;

    localparam int DEPTH   = 4;
    localparam int DEPTH_N = 2;

    logic               iCLOCK = 1'b0;
    logic               iRESET = 1'b1;
    logic               iFLUSH = 1'b0;
    logic               iPUSH_STB = 1'b0;
    logic [31:0]        iPUSH_INST_ADDR = '0;
    logic               iPUSH_PREDICT_HIT = 1'b0;
    logic               iPUSH_PREDICT_BRANCH = 1'b0;
    logic [31:0]        iPUSH_PREDICT_ADDR = '0;
    logic               oPUSH_FULL;
    logic               iRESOLVE_STB = 1'b0;
    logic               iRESOLVE_TAKEN = 1'b0;
    logic [31:0]        iRESOLVE_ADDR = '0;
    logic               oRESOLVE_ERROR;
    logic               oJUMP_STB;
    logic               oJUMP_VALID;
    logic [31:0]        oJUMP_ADDR;
    logic [31:0]        oJUMP_INST_ADDR;
    logic               oMISS_STB;
    logic [31:0]        oMISS_ADDR;
    logic [DEPTH_N:0]   oCOUNT;
    logic [31:0]        oSTAT_RESOLVE;
    logic [31:0]        oSTAT_MISS;

    branch_resolve_queue #(.DEPTH(DEPTH), .DEPTH_N(DEPTH_N)) dut (
        .iCLOCK(iCLOCK), .iRESET(iRESET), .iFLUSH(iFLUSH),
        .iPUSH_STB(iPUSH_STB), .iPUSH_INST_ADDR(iPUSH_INST_ADDR),
        .iPUSH_PREDICT_HIT(iPUSH_PREDICT_HIT),
        .iPUSH_PREDICT_BRANCH(iPUSH_PREDICT_BRANCH),
        .iPUSH_PREDICT_ADDR(iPUSH_PREDICT_ADDR),
        .oPUSH_FULL(oPUSH_FULL),
        .iRESOLVE_STB(iRESOLVE_STB), .iRESOLVE_TAKEN(iRESOLVE_TAKEN),
        .iRESOLVE_ADDR(iRESOLVE_ADDR), .oRESOLVE_ERROR(oRESOLVE_ERROR),
        .oJUMP_STB(oJUMP_STB), .oJUMP_VALID(oJUMP_VALID),
        .oJUMP_ADDR(oJUMP_ADDR), .oJUMP_INST_ADDR(oJUMP_INST_ADDR),
        .oMISS_STB(oMISS_STB), .oMISS_ADDR(oMISS_ADDR),
        .oCOUNT(oCOUNT), .oSTAT_RESOLVE(oSTAT_RESOLVE),
        .oSTAT_MISS(oSTAT_MISS)
    );

    always #5 iCLOCK = ~iCLOCK;

    typedef struct {
        logic [31:0] inst;
        logic        hit;
        logic        br;
        logic [31:0] paddr;
    } ent_t;

    typedef struct {
        logic        jstb;
        logic        jvalid;
        logic [31:0] jaddr;
        logic [31:0] jinst;
        logic        mstb;
        logic [31:0] maddr;
        logic        err;
        int          count;
        logic [31:0] sres;
        logic [31:0] smiss;
    } exp_t;

    ent_t mq[$];
    exp_t sb[$];

    logic        m_jvalid;
    logic [31:0] m_jaddr;
    logic [31:0] m_jinst;
    logic [31:0] m_maddr;
    logic [31:0] m_sres;
    logic [31:0] m_smiss;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_jvalid = 1'b0;
        m_jaddr  = '0;
        m_jinst  = '0;
        m_maddr  = '0;
        m_sres   = '0;
        m_smiss  = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_full"}, 32'(oPUSH_FULL), 32'h0);
        chk({tag, "_err"},  32'(oRESOLVE_ERROR), 32'h0);
        chk({tag, "_jstb"}, 32'(oJUMP_STB), 32'h0);
        chk({tag, "_jval"}, 32'(oJUMP_VALID), 32'h0);
        chk({tag, "_jadr"}, oJUMP_ADDR, 32'h0);
        chk({tag, "_jins"}, oJUMP_INST_ADDR, 32'h0);
        chk({tag, "_mstb"}, 32'(oMISS_STB), 32'h0);
        chk({tag, "_madr"}, oMISS_ADDR, 32'h0);
        chk({tag, "_cnt"},  32'(oCOUNT), 32'h0);
        chk({tag, "_sres"}, oSTAT_RESOLVE, 32'h0);
        chk({tag, "_smis"}, oSTAT_MISS, 32'h0);
    endtask

    // One clock: drive inputs, predict outputs, compare after the edge.
    task automatic cycle(input string tag,
                         input bit p, input logic [31:0] pa,
                         input bit ph, input bit pb, input logic [31:0] pt,
                         input bit r, input bit rt, input logic [31:0] ra,
                         input bit f);
        exp_t e;
        ent_t h;
        ent_t n;
        bit   pop;
        bit   miss;
        bit   full;
        bit   pt_taken;
        iPUSH_STB            = p;
        iPUSH_INST_ADDR      = pa;
        iPUSH_PREDICT_HIT    = ph;
        iPUSH_PREDICT_BRANCH = pb;
        iPUSH_PREDICT_ADDR   = pt;
        iRESOLVE_STB         = r;
        iRESOLVE_TAKEN       = rt;
        iRESOLVE_ADDR        = ra;
        iFLUSH               = f;
        e.jstb = 1'b0;
        e.mstb = 1'b0;
        e.err  = 1'b0;
        miss   = 1'b0;
        full   = (mq.size() == DEPTH);
        pop    = r && (mq.size() > 0) && !f;
        if (f) begin
            mq.delete();
        end else begin
            e.err = r && (mq.size() == 0);
            if (pop) begin
                h = mq.pop_front();
                pt_taken = h.hit & h.br;
                miss = (pt_taken != rt) || (rt && pt_taken && h.paddr != ra);
                e.jstb   = 1'b1;
                m_jvalid = rt;
                m_jaddr  = ra;
                m_jinst  = h.inst;
                m_sres   = m_sres + 32'd1;
                if (miss) begin
                    e.mstb  = 1'b1;
                    m_maddr = rt ? ra : h.inst + 32'h4;
                    m_smiss = m_smiss + 32'd1;
                    mq.delete();
                end
            end
            if (p && (!full || pop) && !(pop && miss)) begin
                n.inst  = pa;
                n.hit   = ph;
                n.br    = pb;
                n.paddr = pt;
                mq.push_back(n);
            end
        end
        e.jvalid = m_jvalid;
        e.jaddr  = m_jaddr;
        e.jinst  = m_jinst;
        e.maddr  = m_maddr;
        e.count  = mq.size();
`ifdef BRANCH_RESOLVE_STAT_EN
        e.sres   = m_sres;
        e.smiss  = m_smiss;
`else
        e.sres   = 32'h0;
        e.smiss  = 32'h0;
`endif
        sb.push_back(e);
        @(posedge iCLOCK);
        #1;
        e = sb.pop_front();
        chk({tag, "_jstb"}, 32'(oJUMP_STB), 32'(e.jstb));
        chk({tag, "_jval"}, 32'(oJUMP_VALID), 32'(e.jvalid));
        chk({tag, "_jadr"}, oJUMP_ADDR, e.jaddr);
        chk({tag, "_jins"}, oJUMP_INST_ADDR, e.jinst);
        chk({tag, "_mstb"}, 32'(oMISS_STB), 32'(e.mstb));
        chk({tag, "_madr"}, oMISS_ADDR, e.maddr);
        chk({tag, "_err"},  32'(oRESOLVE_ERROR), 32'(e.err));
        chk({tag, "_cnt"},  32'(oCOUNT), 32'(e.count));
        chk({tag, "_full"}, 32'(oPUSH_FULL), 32'(e.count == DEPTH));
        chk({tag, "_sres"}, oSTAT_RESOLVE, e.sres);
        chk({tag, "_smis"}, oSTAT_MISS, e.smiss);
        iPUSH_STB    = 1'b0;
        iRESOLVE_STB = 1'b0;
        iFLUSH       = 1'b0;
    endtask

    task automatic push(input string tag, input logic [31:0] a,
                        input bit h, input bit b, input logic [31:0] t);
        cycle(tag, 1, a, h, b, t, 0, 0, 32'h0, 0);
    endtask

    task automatic resolve(input string tag, input bit tk,
                           input logic [31:0] a);
        cycle(tag, 0, 32'h0, 0, 0, 32'h0, 1, tk, a, 0);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    endtask

    task automatic sync_reset();
        @(negedge iCLOCK);
        iRESET = 1'b1;
        #1;
        model_reset();
        @(negedge iCLOCK);
        iRESET = 1'b0;
        @(posedge iCLOCK);
        #1;
    endtask

    initial begin
        model_reset();
        #1;
        chk_zero("rst");
        @(negedge iCLOCK);
        iRESET = 1'b0;
        @(posedge iCLOCK);
        #1;

        push("t1p", 32'h100, 1, 1, 32'h200);
        resolve("t1r", 1, 32'h200);
        chk("t1_stb",  32'(oJUMP_STB), 32'h1);
        chk("t1_val",  32'(oJUMP_VALID), 32'h1);
        chk("t1_inst", oJUMP_INST_ADDR, 32'h100);
        chk("t1_addr", oJUMP_ADDR, 32'h200);
        chk("t1_miss", 32'(oMISS_STB), 32'h0);
        chk("t1_cnt",  32'(oCOUNT), 32'h0);

        push("t2p", 32'h100, 1, 1, 32'h200);
        resolve("t2r", 0, 32'h0);
        chk("t2_miss", 32'(oMISS_STB), 32'h1);
        chk("t2_madr", oMISS_ADDR, 32'h104);
        chk("t2_val",  32'(oJUMP_VALID), 32'h0);

        push("t3p0", 32'h100, 1, 1, 32'h200);
        push("t3p1", 32'h110, 1, 1, 32'h210);
        push("t3p2", 32'h120, 0, 0, 32'h0);
        cycle("t3r", 1, 32'h130, 1, 1, 32'h230, 1, 1, 32'h300, 0);
        chk("t3_madr", oMISS_ADDR, 32'h300);
        chk("t3_cnt",  32'(oCOUNT), 32'h0);
        idle("t3i");

        for (int i = 0; i < 4; i++)
            push("t4fill", 32'h400 + 32'(i) * 4, 1, 1, 32'h800 + 32'(i) * 4);
        chk("t4_full", 32'(oPUSH_FULL), 32'h1);
        push("t4drop", 32'hDEAD0, 1, 1, 32'hBEEF0);
        chk("t4_cnt", 32'(oCOUNT), 32'h4);
        for (int i = 0; i < 6; i++)
            cycle("t4wrap", 1, 32'h410 + 32'(i) * 4, 1, 1,
                  32'h810 + 32'(i) * 4, 1, 1, 32'h800 + 32'(i) * 4, 0);
        chk("t4_cntw", 32'(oCOUNT), 32'h4);
        for (int i = 6; i < 10; i++)
            resolve("t4drain", 1, 32'h800 + 32'(i) * 4);
        chk("t4_last", oJUMP_INST_ADDR, 32'h424);

        resolve("t5e", 1, 32'h0);
        chk("t5_err", 32'(oRESOLVE_ERROR), 32'h1);
        chk("t5_stb", 32'(oJUMP_STB), 32'h0);
        idle("t5i");

        push("t6p0", 32'h500, 1, 1, 32'h600);
        push("t6p1", 32'h504, 0, 0, 32'h0);
        cycle("t6f", 1, 32'h508, 0, 0, 32'h0, 1, 0, 32'h0, 1);
        chk("t6_stb", 32'(oJUMP_STB), 32'h0);
        chk("t6_cnt", 32'(oCOUNT), 32'h0);

        sync_reset();
        push("s0p", 32'h700, 1, 1, 32'h900);
        resolve("s0r", 1, 32'h900);
        push("s1p", 32'h704, 1, 1, 32'h904);
        resolve("s1r", 0, 32'h0);
        push("s2p", 32'h708, 0, 0, 32'h0);
        resolve("s2r", 0, 32'h0);
        push("s3p", 32'h70C, 0, 0, 32'h0);
        resolve("s3r", 1, 32'hA00);
        push("s4p", 32'h710, 1, 0, 32'h0);
        resolve("s4r", 0, 32'h0);
`ifdef BRANCH_RESOLVE_STAT_EN
        chk("st_res",  oSTAT_RESOLVE, 32'd5);
        chk("st_miss", oSTAT_MISS, 32'd2);
`else
        chk("st_res",  oSTAT_RESOLVE, 32'h0);
        chk("st_miss", oSTAT_MISS, 32'h0);
`endif

        push("r0p", 32'hB00, 1, 1, 32'hC00);
        push("r1p", 32'hB04, 1, 1, 32'hC04);
        resolve("r0r", 1, 32'hC00);
        #2;
        iRESET = 1'b1;
        #1;
        model_reset();
        chk_zero("arst");
        @(negedge iCLOCK);
        iRESET = 1'b0;
        @(posedge iCLOCK);
        #1;
        push("ap", 32'hD00, 1, 1, 32'hE00);
        resolve("ar", 1, 32'hE00);
        chk("a_inst", oJUMP_INST_ADDR, 32'hD00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
